// File: rtl/imem_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the fetch controller's memory, decode-handshake, redirect and run
// signals.
//   master : fetch controller side (drives Address, Inst_out, Pc_out,
//            Inst_valid, Halted)
//   slave  : environment side (memory, decode, execute, run control)
// Parameters: ADDR_W (address width), DATA_W (instruction width).
// ----------------------------------------------------------------------------
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              Run;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Instruction;
    logic [DATA_W-1:0] Inst_out;
    logic [ADDR_W-1:0] Pc_out;
    logic              Inst_valid;
    logic              Inst_ready;
    logic              Jump_en;
    logic [ADDR_W-1:0] Jump_target;
    logic              Halted;

    modport master (
        input  Run, Instruction, Inst_ready, Jump_en, Jump_target,
        output Address, Inst_out, Pc_out, Inst_valid, Halted
    );

    modport slave (
        output Run, Instruction, Inst_ready, Jump_en, Jump_target,
        input  Address, Inst_out, Pc_out, Inst_valid, Halted
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer for an instruction memory with combinational read. Owns the
// program counter (driven straight out as Address), captures the returned
// Instruction into a one-entry slot and offers it to decode over a
// valid/ready handshake. Execute can redirect with Jump_en/Jump_target; Run
// starts and stops fetching.
// Ports:
//   Clk    : rising-edge clock
//   Reset  : asynchronous active-low reset
//   bus    : imem_fetch_ctrl_if.master (Run, Address, Instruction, Inst_out,
//            Pc_out, Inst_valid, Inst_ready, Jump_en, Jump_target, Halted)
// Optional feature macro: HALT_DETECT_EN -- when defined, capturing
//   HALT_OPCODE parks the sequencer in a HALT state until a jump or reset.
//   When undefined, HALT_OPCODE is an ordinary instruction and Halted is 0.
// ----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
    parameter logic [ADDR_W-1:0] LAST_ADDR   = 8'hFF
`ifdef HALT_DETECT_EN
    ,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
`endif
) (
    input  logic               Clk,
    input  logic               Reset,
    imem_fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1
`ifdef HALT_DETECT_EN
        ,
        ST_HALT  = 2'd2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              valid_q, valid_d;
    logic              slot_free;
`ifdef HALT_DETECT_EN
    logic              halted_q, halted_d;
`endif

    // The slot may be refilled on an edge where its current content leaves.
    assign slot_free = !valid_q || bus.Inst_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;

        // Handshake drain; a capture below overrides this with 1.
        if (valid_q && bus.Inst_ready) begin
            valid_d = 1'b0;
        end

        if (bus.Jump_en) begin
            // Redirect flushes the slot; a transfer completing on the same
            // edge was already counted by the drain above.
            pc_d    = bus.Jump_target;
            valid_d = 1'b0;
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_FETCH: state_d = bus.Run ? ST_FETCH : ST_IDLE;
`ifdef HALT_DETECT_EN
                ST_HALT:  state_d = bus.Run ? ST_FETCH : ST_IDLE;
`endif
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Run) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!bus.Run) begin
                        // Stop capturing; leave once the slot has drained.
                        if (slot_free) begin
                            state_d = ST_IDLE;
                        end
                    end else if (slot_free) begin
                        inst_d   = bus.Instruction;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_W'(1);
`ifdef HALT_DETECT_EN
                        // The halt word itself is delivered; PC stays on it.
                        if (bus.Instruction == HALT_OPCODE) begin
                            pc_d    = pc_q;
                            state_d = ST_HALT;
                        end
`endif
                    end
                end
                default: begin
                    // HALT (when present): only the drain above applies.
                end
            endcase
        end
`ifdef HALT_DETECT_EN
        halted_d = (state_d == ST_HALT);
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
`ifdef HALT_DETECT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
`ifdef HALT_DETECT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign bus.Address    = pc_q;
    assign bus.Inst_out   = inst_q;
    assign bus.Pc_out     = pc_out_q;
    assign bus.Inst_valid = valid_q;
`ifdef HALT_DETECT_EN
    assign bus.Halted     = halted_q;
`else
    assign bus.Halted     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Scoreboard bench for imem_fetch_ctrl: each scenario pushes the (address,
// instruction) pairs it expects decode to receive and pops them as the DUT
// offers Inst_valid with Inst_ready high. Also exercises the macro
// HALT_DETECT_EN behaviour (either branch) in test_halt.
// ----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] inst;
    } exp_t;

    logic Clk    = 1'b0;
    logic Reset  = 1'b0;
    logic clk_en = 1'b1;

    logic [7:0] mem [256];
    exp_t       sb_q [$];
    exp_t       exp_e;
    int         n_checks = 0;
    int         n_fail   = 0;

    imem_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    imem_fetch_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Combinational-read instruction memory model.
    assign bus.Instruction = mem[bus.Address];

    always begin
        #5;
        if (clk_en) Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push_exp(input logic [7:0] a);
        sb_q.push_back('{pc: a, inst: mem[a]});
    endtask

    task automatic test_reset;
        bus.Run = 1'b0; bus.Inst_ready = 1'b0; bus.Jump_en = 1'b0; bus.Jump_target = 8'h00;
        Reset = 1'b0;
        tick; tick;
        n_checks++;
        if (bus.Inst_valid !== 1'b0 || bus.Inst_out !== 8'h00 || bus.Pc_out !== 8'h00 ||
            bus.Halted !== 1'b0 || bus.Address !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b inst=%h pc_out=%h halted=%b addr=%h, required 0/00/00/0/%h",
                     bus.Inst_valid, bus.Inst_out, bus.Pc_out, bus.Halted, bus.Address, RESET_PC);
        end
        Reset = 1'b1;
        tick; tick;
        n_checks++;
        if (bus.Inst_valid !== 1'b0 || bus.Address !== RESET_PC) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b addr=%h, required 0/%h",
                     bus.Inst_valid, bus.Address, RESET_PC);
        end
    endtask

    task automatic test_fetch;
        int c = 0;
        int k = 0;
        push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
        bus.Run = 1'b1; bus.Inst_ready = 1'b1;
        while (sb_q.size() > 0 && c < 10) begin
            tick; c++;
            if (bus.Inst_valid && bus.Inst_ready) begin
                exp_e = sb_q.pop_front();
                $display("fetch: cycle=%0d pc_out=%h inst=%h", c, bus.Pc_out, bus.Inst_out);
                n_checks++;
                if (bus.Pc_out !== exp_e.pc || bus.Inst_out !== exp_e.inst || c != 2 + k) begin
                    n_fail++;
                    $display("FAIL fetch_seq: pc_out=%h inst=%h cycle=%0d, required %h/%h cycle=%0d",
                             bus.Pc_out, bus.Inst_out, c, exp_e.pc, exp_e.inst, 2 + k);
                end
                k++;
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL fetch_timeout: %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
        // Stop: last instruction drains, no new capture.
        bus.Run = 1'b0;
        tick;
        n_checks++;
        if (bus.Inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_drain: valid=%b, required 0", bus.Inst_valid);
        end
        // Jump while idle loads the PC only.
        bus.Jump_en = 1'b1; bus.Jump_target = 8'h00;
        tick;
        bus.Jump_en = 1'b0;
        n_checks++;
        if (bus.Address !== 8'h00 || bus.Inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_jump: addr=%h valid=%b, required 00/0", bus.Address, bus.Inst_valid);
        end
    endtask

    task automatic test_stall;
        push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
        bus.Run = 1'b1; bus.Inst_ready = 1'b1;
        tick; tick;
        exp_e = sb_q.pop_front();
        $display("stall: pc_out=%h inst=%h", bus.Pc_out, bus.Inst_out);
        n_checks++;
        if (bus.Inst_valid !== 1'b1 || bus.Pc_out !== exp_e.pc || bus.Inst_out !== exp_e.inst) begin
            n_fail++;
            $display("FAIL stall_first: valid=%b pc_out=%h inst=%h, required 1/%h/%h",
                     bus.Inst_valid, bus.Pc_out, bus.Inst_out, exp_e.pc, exp_e.inst);
        end
        tick;
        bus.Inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (bus.Inst_valid !== 1'b1 || bus.Pc_out !== 8'h01 || bus.Inst_out !== mem[1] ||
                bus.Address !== 8'h02) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b pc_out=%h inst=%h addr=%h, required 1/01/%h/02",
                         bus.Inst_valid, bus.Pc_out, bus.Inst_out, bus.Address, mem[1]);
            end
        end
        bus.Inst_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick;
            exp_e = sb_q.pop_front();
            $display("stall: pc_out=%h inst=%h", bus.Pc_out, bus.Inst_out);
            n_checks++;
            if (bus.Inst_valid !== 1'b1 || bus.Pc_out !== exp_e.pc || bus.Inst_out !== exp_e.inst) begin
                n_fail++;
                $display("FAIL stall_resume: valid=%b pc_out=%h inst=%h, required 1/%h/%h",
                         bus.Inst_valid, bus.Pc_out, bus.Inst_out, exp_e.pc, exp_e.inst);
            end
        end
        tick;
    endtask

    task automatic test_jump;
        // Slot holds pc 3 undelivered when the redirect arrives.
        bus.Inst_ready = 1'b0; bus.Jump_en = 1'b1; bus.Jump_target = 8'h05;
        tick;
        bus.Jump_en = 1'b0;
        n_checks++;
        if (bus.Inst_valid !== 1'b0 || bus.Address !== 8'h05) begin
            n_fail++;
            $display("FAIL jump_flush: valid=%b addr=%h, required 0/05", bus.Inst_valid, bus.Address);
        end
        bus.Inst_ready = 1'b1;
        push_exp(8'h05); push_exp(8'h06);
        for (int i = 0; i < 2; i++) begin
            tick;
            exp_e = sb_q.pop_front();
            $display("jump: pc_out=%h inst=%h", bus.Pc_out, bus.Inst_out);
            n_checks++;
            if (bus.Inst_valid !== 1'b1 || bus.Pc_out !== exp_e.pc || bus.Inst_out !== exp_e.inst) begin
                n_fail++;
                $display("FAIL jump_target: valid=%b pc_out=%h inst=%h, required 1/%h/%h",
                         bus.Inst_valid, bus.Pc_out, bus.Inst_out, exp_e.pc, exp_e.inst);
            end
        end
    endtask

    task automatic test_wrap;
        int c = 0;
        bus.Jump_en = 1'b1; bus.Jump_target = 8'hFE;
        tick;
        bus.Jump_en = 1'b0;
        n_checks++;
        if (bus.Inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_flush: valid=%b, required 0", bus.Inst_valid);
        end
        push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01);
        while (sb_q.size() > 0 && c < 8) begin
            tick; c++;
            if (bus.Inst_valid && bus.Inst_ready) begin
                exp_e = sb_q.pop_front();
                $display("wrap: pc_out=%h inst=%h", bus.Pc_out, bus.Inst_out);
                n_checks++;
                if (bus.Pc_out !== exp_e.pc || bus.Inst_out !== exp_e.inst) begin
                    n_fail++;
                    $display("FAIL wrap_seq: pc_out=%h inst=%h, required %h/%h",
                             bus.Pc_out, bus.Inst_out, exp_e.pc, exp_e.inst);
                end
            end
        end
        n_checks++;
        if (sb_q.size() != 0 || c != 4) begin
            n_fail++;
            $display("FAIL wrap_rate: pending=%0d cycles=%0d, required 0/4", sb_q.size(), c);
            sb_q.delete();
        end
    endtask

    task automatic test_async_reset;
        clk_en = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if (bus.Inst_valid !== 1'b0 || bus.Address !== RESET_PC || bus.Pc_out !== 8'h00 ||
            bus.Inst_out !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b addr=%h pc_out=%h inst=%h, required 0/%h/00/00",
                     bus.Inst_valid, bus.Address, bus.Pc_out, bus.Inst_out, RESET_PC);
        end
        bus.Run = 1'b0;
        #5;
        Reset = 1'b1;
        clk_en = 1'b1;
        tick;
        n_checks++;
        if (bus.Inst_valid !== 1'b0 || bus.Address !== RESET_PC) begin
            n_fail++;
            $display("FAIL post_reset_idle: valid=%b addr=%h, required 0/%h",
                     bus.Inst_valid, bus.Address, RESET_PC);
        end
    endtask

    task automatic test_halt;
        int c = 0;
        mem[4] = 8'hFF;
        mem[5] = 8'h5A;
        for (int a = 0; a < 5; a++) push_exp(8'(a));
        bus.Run = 1'b1; bus.Inst_ready = 1'b1;
        while (sb_q.size() > 0 && c < 12) begin
            tick; c++;
            if (bus.Inst_valid && bus.Inst_ready) begin
                exp_e = sb_q.pop_front();
                $display("halt: pc_out=%h inst=%h halted=%b", bus.Pc_out, bus.Inst_out, bus.Halted);
                n_checks++;
                if (bus.Pc_out !== exp_e.pc || bus.Inst_out !== exp_e.inst) begin
                    n_fail++;
                    $display("FAIL halt_seq: pc_out=%h inst=%h, required %h/%h",
                             bus.Pc_out, bus.Inst_out, exp_e.pc, exp_e.inst);
                end
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL halt_timeout: %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
`ifdef HALT_DETECT_EN
        n_checks++;
        if (bus.Halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_flag: halted=%b, required 1", bus.Halted);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (bus.Inst_valid !== 1'b0 || bus.Halted !== 1'b1 || bus.Address !== 8'h04) begin
                n_fail++;
                $display("FAIL halt_hold: valid=%b halted=%b addr=%h, required 0/1/04",
                         bus.Inst_valid, bus.Halted, bus.Address);
            end
        end
        bus.Jump_en = 1'b1; bus.Jump_target = 8'h00;
        tick;
        bus.Jump_en = 1'b0;
        n_checks++;
        if (bus.Halted !== 1'b0 || bus.Address !== 8'h00) begin
            n_fail++;
            $display("FAIL halt_exit: halted=%b addr=%h, required 0/00", bus.Halted, bus.Address);
        end
        tick;
        $display("halt: resume pc_out=%h inst=%h", bus.Pc_out, bus.Inst_out);
        n_checks++;
        if (bus.Inst_valid !== 1'b1 || bus.Pc_out !== 8'h00 || bus.Inst_out !== mem[0]) begin
            n_fail++;
            $display("FAIL halt_resume: valid=%b pc_out=%h inst=%h, required 1/00/%h",
                     bus.Inst_valid, bus.Pc_out, bus.Inst_out, mem[0]);
        end
`else
        n_checks++;
        if (bus.Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_flag: halted=%b, required 0", bus.Halted);
        end
        tick;
        $display("halt: next pc_out=%h inst=%h", bus.Pc_out, bus.Inst_out);
        n_checks++;
        if (bus.Inst_valid !== 1'b1 || bus.Pc_out !== 8'h05 || bus.Inst_out !== 8'h5A ||
            bus.Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_ordinary: valid=%b pc_out=%h inst=%h halted=%b, required 1/05/5a/0",
                     bus.Inst_valid, bus.Pc_out, bus.Inst_out, bus.Halted);
        end
`endif
    endtask

    initial begin
        // Fill never produces 8'hFF, so the halt word appears only where placed.
        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 7 + 3) & 8'h7F);
        mem[0] = 8'h27; mem[1] = 8'h61; mem[2] = 8'h3C;

        test_reset;
        test_fetch;
        test_stall;
        test_jump;
        test_wrap;
        test_async_reset;
        test_halt;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
